pc_interface_handler_mc: RTL and testbench
==========================================

Name: pc_interface_handler_mc

Overview:
Multi-bank successor of the PC/UART command handler. It parses byte frames from the UART receive FIFO and performs burst reads and writes on up to 4 register banks of arbitrary word width. It returns read data or a status byte to the UART transmit FIFO. The timeout is live, and an optional checksum protects frames. It sits between the UART core and the signal-generator register banks.

Parameters:
BANK_DATA_WIDTH, 16, bank word width in bits (1..64); bytes per word B = ceil(W/8).
BANK_ADDR_WIDTH, 3, word address width per bank (1..5).
NUM_BANKS, 2, number of banks (1..4).
UART_TIMEOUT_WIDTH, 16, width of the idle-byte timeout counter; timeout after 2^N-1 cycles.

Ports:
i_clk  in  1  clock
i_arst_n  in  1  async reset, active-low
i_pc_valid  in  1  RX FIFO has a byte
i_pc_data  in  8  RX byte
o_pc_rd  out  1  RX pop strobe
i_pc_rdy  in  1  TX FIFO can accept a byte
o_pc_data  out  8  TX byte
o_pc_wr  out  1  TX push strobe
i_bank_data  in  NUM_BANKS*BANK_DATA_WIDTH  flat read-data bus; bank k occupies slice [k*W +: W]
o_bank_data  out  BANK_DATA_WIDTH  write data
o_bank_addr  out  BANK_ADDR_WIDTH  word address, shared by all banks
o_bank_wr  out  NUM_BANKS  one-hot write strobe
o_busy  out  1  high whenever FSM is not in S_IDLE
o_timeout  out  1  one-cycle pulse on frame abort

Behaviour:
- Reset: i_arst_n is an asynchronous, active-low reset; the clock is i_clk. Reset returns the FSM to S_IDLE and clears all registers. All outputs are 0 during and after reset. Reset mid-frame aborts the frame; no strobe or byte is emitted.
- Frame layout, MSB of each byte first:
  - CMD byte: [7]=write, [6:5]=bank, [4:0]=start addr (low BANK_ADDR_WIDTH bits used).
  - LEN byte: word count minus 1 (0..255).
  - Write frames: (LEN+1)*B data bytes follow, MS byte of each word first.
- RX handshake: a byte is consumed in any cycle where the state expects a byte and i_pc_valid=1. o_pc_rd=1 in that same cycle (combinational), and the byte is captured at that edge.
- TX handshake: in the send state, o_pc_wr=1 in the cycle i_pc_rdy=1, with o_pc_data valid that cycle. o_pc_wr is never asserted while i_pc_rdy=0.
- States and transitions:
  - S_IDLE: consume CMD -> S_LEN.
  - S_LEN: consume LEN, load word counter -> S_WR_BYTE if write, else S_RD_LOAD.
  - S_WR_BYTE: shift bytes in. After B bytes -> S_WR_STROBE.
  - S_WR_STROBE: o_bank_wr[bank]=1 for one cycle; o_bank_data = low W bits of the assembled word, upper pad bits discarded. Then advance address. If words remain -> S_WR_BYTE, else -> S_STATUS.
  - S_RD_LOAD: sample the i_bank_data slice one cycle after o_bank_addr settles (combinational bank read); zero-extend to B*8 bits -> S_RD_SEND.
  - S_RD_SEND: send B bytes, MS byte first. Then advance address. If words remain -> S_RD_LOAD, else -> S_IDLE (or S_CHK_SEND with the option).
  - S_STATUS: send 0xA5 (ACK) -> S_IDLE.
- Address: increments by 1 per word and wraps modulo 2^BANK_ADDR_WIDTH within the selected bank.
- Bank index >= NUM_BANKS: the frame is fully consumed, no o_bank_wr is asserted, and reads return 0x00 bytes. The status byte is 0x5A (NAK).
- Timeout:
  - The counter runs only in S_LEN and S_WR_BYTE and clears on each consumed byte.
  - When it reaches all-ones: o_timeout pulses for one cycle, the FSM goes to S_IDLE, and no status byte is sent.
  - Waiting on i_pc_rdy never times out.
- CMD arriving while busy: not possible, since bytes are consumed only per the FSM.
- Simultaneous i_pc_valid with a timeout expiry: timeout wins and the byte is left in the FIFO.

Optional Feature:
PC_IF_CHECKSUM_EN.
- Defined:
  - Write frames carry one trailing byte, the XOR of CMD, LEN and all data bytes.
  - The status byte is 0xA5 on match and 0x5A on mismatch or invalid bank. Writes are already committed, so the status is informational only.
  - Read frames append one byte: the XOR of CMD, LEN and all sent data bytes (S_CHK_SEND).
  - The trailing checksum byte is subject to the timeout.
- Undefined: no checksum bytes, and the status byte is as described above.

Test Plan:
Unless noted: W=16, A=3, NUM_BANKS=2, UART_TIMEOUT_WIDTH=4, checksum off.
1. Write CMD 0x82, LEN 0x01, data 12 34 AB CD -> o_bank_wr=01 at addr 2 with 0x1234, then at addr 3 with 0xABCD; TX byte 0xA5; o_busy low afterwards.
2. Bank1 addr 7 holds 0xBEEF and addr 0 holds 0x0042; send CMD 0x27, LEN 0x01 -> TX BE EF 00 42 (address wrap); o_bank_wr stays 0.
3. Send CMD 0x82, LEN 0x00, data 12, then idle 15 cycles -> o_timeout pulses once, no write, no TX byte; a next frame is processed normally.
4. Send CMD 0xC0 (bank 2, invalid), LEN 0x00, data 00 01 -> no o_bank_wr; TX byte 0x5A.
5. Checksum on: send CMD 0x80, LEN 0x00, data 00 05, chk 0x85 -> write 0x0005 and TX 0xA5. Repeat with chk 0x00 -> write occurs and TX 0x5A.
6. Hold i_pc_rdy low for 20 cycles during a read -> no o_pc_wr, no timeout; bytes resume in order when i_pc_rdy rises. Assert reset mid-frame -> all outputs 0 and the FSM is in S_IDLE.

Source files
------------

// File: rtl/pc_interface_handler_mc.sv
// UART byte-frame command handler doing burst reads/writes on up to four register banks.
// Define PC_IF_CHECKSUM_EN to add an XOR checksum byte to write and read frames.
module pc_interface_handler_mc #(
    parameter int unsigned BANK_DATA_WIDTH    = 16,
    parameter int unsigned BANK_ADDR_WIDTH    = 3,
    parameter int unsigned NUM_BANKS          = 2,
    parameter int unsigned UART_TIMEOUT_WIDTH = 16
) (
    input  logic                                 i_clk,
    input  logic                                 i_arst_n,
    input  logic                                 i_pc_valid,
    input  logic [7:0]                           i_pc_data,
    output logic                                 o_pc_rd,
    input  logic                                 i_pc_rdy,
    output logic [7:0]                           o_pc_data,
    output logic                                 o_pc_wr,
    input  logic [NUM_BANKS*BANK_DATA_WIDTH-1:0] i_bank_data,
    output logic [BANK_DATA_WIDTH-1:0]           o_bank_data,
    output logic [BANK_ADDR_WIDTH-1:0]           o_bank_addr,
    output logic [NUM_BANKS-1:0]                 o_bank_wr,
    output logic                                 o_busy,
    output logic                                 o_timeout
);

    localparam int unsigned BYTES = (BANK_DATA_WIDTH + 7) / 8;
    localparam int unsigned WB    = BYTES * 8;
    localparam logic [7:0]  ACK   = 8'hA5;
    localparam logic [7:0]  NAK   = 8'h5A;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN,
        S_WR_BYTE,
        S_WR_STROBE,
        S_WR_CHK,
        S_RD_LOAD,
        S_RD_SEND,
        S_CHK_SEND,
        S_STATUS
    } state_t;

    state_t                        state_q, state_d;
    logic [WB-1:0]                 word_q, word_d;
    logic [BANK_ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [1:0]                    bank_q, bank_d;
    logic                          write_q, write_d;
    logic [7:0]                    words_q, words_d;
    logic [2:0]                    bytes_q, bytes_d;
    logic [7:0]                    chk_q, chk_d;
    logic [UART_TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
    logic                          rx_en_q;

    logic                       bank_ok;
    logic                       tmo_hit;
    logic                       rx_take;
    logic                       last_byte;
    logic [7:0]                 status;
    logic [BANK_DATA_WIDTH-1:0] rd_word;

    assign bank_ok   = {30'd0, bank_q} < NUM_BANKS;
    assign last_byte = bytes_q == 3'(BYTES - 1);
    // rx_en_q keeps o_pc_rd low while reset is asserted
    assign rx_take   = i_pc_valid && rx_en_q;
    assign tmo_hit   = (state_q inside {S_LEN, S_WR_BYTE, S_WR_CHK}) && (&tmo_q);

`ifdef PC_IF_CHECKSUM_EN
    // chk_q includes the received checksum byte, so a clean frame folds to zero
    assign status = (bank_ok && chk_q == 8'h00) ? ACK : NAK;
`else
    assign status = bank_ok ? ACK : NAK;
`endif

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (bank_q == 2'(k)) begin
                rd_word = i_bank_data[k*BANK_DATA_WIDTH +: BANK_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        o_bank_wr = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            o_bank_wr[k] = (state_q == S_WR_STROBE) && (bank_q == 2'(k));
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        addr_d    = addr_q;
        bank_d    = bank_q;
        write_d   = write_q;
        words_d   = words_q;
        bytes_d   = bytes_q;
        chk_d     = chk_q;
        tmo_d     = '0;
        o_pc_rd   = 1'b0;
        o_pc_wr   = 1'b0;
        o_pc_data = 8'h00;
        o_timeout = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_take) begin
                    o_pc_rd = 1'b1;
                    write_d = i_pc_data[7];
                    bank_d  = i_pc_data[6:5];
                    addr_d  = i_pc_data[BANK_ADDR_WIDTH-1:0];
                    chk_d   = i_pc_data;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (tmo_hit) begin
                    o_timeout = 1'b1;
                    state_d   = S_IDLE;
                end else if (rx_take) begin
                    o_pc_rd = 1'b1;
                    words_d = i_pc_data;
                    bytes_d = '0;
                    chk_d   = chk_q ^ i_pc_data;
                    state_d = write_q ? S_WR_BYTE : S_RD_LOAD;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WR_BYTE: begin
                if (tmo_hit) begin
                    o_timeout = 1'b1;
                    state_d   = S_IDLE;
                end else if (rx_take) begin
                    o_pc_rd = 1'b1;
                    word_d  = (word_q << 8) | WB'(i_pc_data);
                    chk_d   = chk_q ^ i_pc_data;
                    bytes_d = bytes_q + 3'd1;
                    if (last_byte) begin
                        bytes_d = '0;
                        state_d = S_WR_STROBE;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WR_STROBE: begin
                addr_d = addr_q + 1'b1;
                if (words_q == 8'd0) begin
`ifdef PC_IF_CHECKSUM_EN
                    state_d = S_WR_CHK;
`else
                    state_d = S_STATUS;
`endif
                end else begin
                    words_d = words_q - 8'd1;
                    state_d = S_WR_BYTE;
                end
            end
            S_WR_CHK: begin
                if (tmo_hit) begin
                    o_timeout = 1'b1;
                    state_d   = S_IDLE;
                end else if (rx_take) begin
                    o_pc_rd = 1'b1;
                    chk_d   = chk_q ^ i_pc_data;
                    state_d = S_STATUS;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RD_LOAD: begin
                word_d  = WB'(rd_word);
                bytes_d = '0;
                state_d = S_RD_SEND;
            end
            S_RD_SEND: begin
                o_pc_data = word_q[WB-1 -: 8];
                if (i_pc_rdy) begin
                    o_pc_wr = 1'b1;
                    chk_d   = chk_q ^ word_q[WB-1 -: 8];
                    word_d  = word_q << 8;
                    bytes_d = bytes_q + 3'd1;
                    if (last_byte) begin
                        bytes_d = '0;
                        addr_d  = addr_q + 1'b1;
                        if (words_q == 8'd0) begin
`ifdef PC_IF_CHECKSUM_EN
                            state_d = S_CHK_SEND;
`else
                            state_d = S_IDLE;
`endif
                        end else begin
                            words_d = words_q - 8'd1;
                            state_d = S_RD_LOAD;
                        end
                    end
                end
            end
            S_CHK_SEND: begin
                o_pc_data = chk_q;
                if (i_pc_rdy) begin
                    o_pc_wr = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_STATUS: begin
                o_pc_data = status;
                if (i_pc_rdy) begin
                    o_pc_wr = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            addr_q  <= '0;
            bank_q  <= '0;
            write_q <= 1'b0;
            words_q <= '0;
            bytes_q <= '0;
            chk_q   <= '0;
            tmo_q   <= '0;
            rx_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            bank_q  <= bank_d;
            write_q <= write_d;
            words_q <= words_d;
            bytes_q <= bytes_d;
            chk_q   <= chk_d;
            tmo_q   <= tmo_d;
            rx_en_q <= 1'b1;
        end
    end

    assign o_busy      = state_q != S_IDLE;
    assign o_bank_addr = addr_q;
    assign o_bank_data = word_q[BANK_DATA_WIDTH-1:0];

endmodule

// File: tb/tb_pc_interface_handler_mc.sv
// Self-checking bench for pc_interface_handler_mc: vector table of frames plus
// hand-written sequences for TX back-pressure and mid-frame reset.
module tb_pc_interface_handler_mc;

    localparam int W  = 16;
    localparam int A  = 3;
    localparam int NB = 2;
    localparam int TW = 4;
`ifdef PC_IF_CHECKSUM_EN
    localparam int RdExtra = 1;
`else
    localparam int RdExtra = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pc_valid = 1'b0;
    logic [7:0]    pc_data = 8'h00;
    logic          pc_rdy = 1'b1;
    logic          o_pc_rd, o_pc_wr, o_busy, o_timeout;
    logic [7:0]    o_pc_data;
    logic [NB*W-1:0] bank_data;
    logic [W-1:0]  o_bank_data;
    logic [A-1:0]  o_bank_addr;
    logic [NB-1:0] o_bank_wr;

    pc_interface_handler_mc #(
        .BANK_DATA_WIDTH    (W),
        .BANK_ADDR_WIDTH    (A),
        .NUM_BANKS          (NB),
        .UART_TIMEOUT_WIDTH (TW)
    ) dut (
        .i_clk       (clk),
        .i_arst_n    (rst_n),
        .i_pc_valid  (pc_valid),
        .i_pc_data   (pc_data),
        .o_pc_rd     (o_pc_rd),
        .i_pc_rdy    (pc_rdy),
        .o_pc_data   (o_pc_data),
        .o_pc_wr     (o_pc_wr),
        .i_bank_data (bank_data),
        .o_bank_data (o_bank_data),
        .o_bank_addr (o_bank_addr),
        .o_bank_wr   (o_bank_wr),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout)
    );

    always #5 clk = ~clk;

    // Fixed bank contents, read combinationally from the shared address.
    function automatic logic [15:0] rom(input int b, input logic [2:0] a);
        if (b == 0) return 16'h1000 + 16'(a);
        if (a == 3'd7) return 16'hBEEF;
        if (a == 3'd0) return 16'h0042;
        return 16'h2000 + 16'(a);
    endfunction
    assign bank_data = {rom(1, o_bank_addr), rom(0, o_bank_addr)};

    // RX FIFO model
    logic [7:0] rx_buf [1024];
    int         rx_wr = 0;
    int         rx_rd = 0;
    logic       rd_seen = 1'b0;
    logic       force_valid = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) rx_rd = rx_wr;
        else if (rd_seen) rx_rd = rx_rd + 1;
        if (force_valid) begin
            pc_valid = 1'b1;
            pc_data  = 8'hFF;
        end else if (rx_rd != rx_wr) begin
            pc_valid = 1'b1;
            pc_data  = rx_buf[rx_rd];
        end else begin
            pc_valid = 1'b0;
            pc_data  = 8'h00;
        end
    end

    // Output monitor, sampled mid-cycle
    logic [7:0]  tx_buf [256];
    logic [20:0] wr_buf [256];
    int tx_n = 0, wr_n = 0, tmo_n = 0, proto_bad = 0;

    always @(negedge clk) begin
        rd_seen = o_pc_rd;
        if (o_pc_rd && !pc_valid) proto_bad++;
        if (o_pc_wr) begin
            if (!pc_rdy) proto_bad++;
            tx_buf[tx_n] = o_pc_data;
            tx_n++;
        end
        if (|o_bank_wr) begin
            wr_buf[wr_n] = {o_bank_wr, o_bank_addr, o_bank_data};
            wr_n++;
        end
        if (o_timeout) tmo_n++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [7:0] b);
        rx_buf[rx_wr] = b;
        rx_wr = rx_wr + 1;
    endtask

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (rx_rd == rx_wr && !o_busy) ok = 1'b1;
        end
        check({name, "_done"}, 64'(ok), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_quiet(input string p);
        check({p, "_pc_rd"},     64'(o_pc_rd),     64'd0);
        check({p, "_pc_wr"},     64'(o_pc_wr),     64'd0);
        check({p, "_pc_data"},   64'(o_pc_data),   64'd0);
        check({p, "_bank_wr"},   64'(o_bank_wr),   64'd0);
        check({p, "_bank_addr"}, 64'(o_bank_addr), 64'd0);
        check({p, "_bank_data"}, 64'(o_bank_data), 64'd0);
        check({p, "_busy"},      64'(o_busy),      64'd0);
        check({p, "_timeout"},   64'(o_timeout),   64'd0);
    endtask

    typedef struct {
        logic [63:0] rx;     // frame bytes, first byte in [63:56]
        int          n_rx;
        logic [63:0] tx;     // expected TX bytes, first in [63:56]
        int          n_tx;
        logic [20:0] wr0;    // {strobe, addr, data}
        logic [20:0] wr1;
        int          n_wr;
        int          n_tmo;
    } vec_t;

    vec_t vecs [10];
    int   n_vec;

    task automatic run_vec(input int idx, input vec_t v);
        int    tx0 = tx_n;
        int    wr0 = wr_n;
        int    t0  = tmo_n;
        string p   = $sformatf("v%0d", idx);
        for (int j = 0; j < v.n_rx; j++) push(v.rx[63-8*j -: 8]);
        wait_done(p);
        check({p, "_ntx"}, 64'(tx_n - tx0), 64'(v.n_tx));
        for (int j = 0; j < v.n_tx && j < tx_n - tx0; j++)
            check($sformatf("%s_tx%0d", p, j), 64'(tx_buf[tx0+j]), 64'(v.tx[63-8*j -: 8]));
        check({p, "_nwr"}, 64'(wr_n - wr0), 64'(v.n_wr));
        for (int j = 0; j < v.n_wr && j < wr_n - wr0; j++)
            check($sformatf("%s_wr%0d", p, j), 64'(wr_buf[wr0+j]),
                  64'((j == 0) ? v.wr0 : v.wr1));
        check({p, "_ntmo"}, 64'(tmo_n - t0), 64'(v.n_tmo));
        check({p, "_busy"}, 64'(o_busy), 64'd0);
    endtask

    initial begin
        int tx0, wr0, t0;

`ifdef PC_IF_CHECKSUM_EN
        vecs[0] = '{64'h8000_0005_8500_0000, 5, 64'hA500_0000_0000_0000, 1,
                    {2'b01, 3'd0, 16'h0005}, 21'd0, 1, 0};
        vecs[1] = '{64'h8000_0005_0000_0000, 5, 64'h5A00_0000_0000_0000, 1,
                    {2'b01, 3'd0, 16'h0005}, 21'd0, 1, 0};
        vecs[2] = '{64'h2701_0000_0000_0000, 2, 64'hBEEF_0042_3500_0000, 5,
                    21'd0, 21'd0, 0, 0};
        vecs[3] = '{64'hC000_0001_C100_0000, 5, 64'h5A00_0000_0000_0000, 1,
                    21'd0, 21'd0, 0, 0};
        vecs[4] = '{64'h8200_1200_0000_0000, 3, 64'd0, 0, 21'd0, 21'd0, 0, 1};
        n_vec = 5;
`else
        vecs[0] = '{64'h8201_1234_ABCD_0000, 6, 64'hA500_0000_0000_0000, 1,
                    {2'b01, 3'd2, 16'h1234}, {2'b01, 3'd3, 16'hABCD}, 2, 0};
        vecs[1] = '{64'h2701_0000_0000_0000, 2, 64'hBEEF_0042_0000_0000, 4,
                    21'd0, 21'd0, 0, 0};
        vecs[2] = '{64'h8200_1200_0000_0000, 3, 64'd0, 0, 21'd0, 21'd0, 0, 1};
        vecs[3] = '{64'hC000_0001_0000_0000, 4, 64'h5A00_0000_0000_0000, 1,
                    21'd0, 21'd0, 0, 0};
        vecs[4] = '{64'h0100_0000_0000_0000, 2, 64'h1001_0000_0000_0000, 2,
                    21'd0, 21'd0, 0, 0};
        vecs[5] = '{64'h6000_0000_0000_0000, 2, 64'h0000_0000_0000_0000, 2,
                    21'd0, 21'd0, 0, 0};
        vecs[6] = '{64'hA701_1122_3344_0000, 6, 64'hA500_0000_0000_0000, 1,
                    {2'b10, 3'd7, 16'h1122}, {2'b10, 3'd0, 16'h3344}, 2, 0};
        vecs[7] = '{64'h0500_0000_0000_0000, 1, 64'd0, 0, 21'd0, 21'd0, 0, 1};
        vecs[8] = '{64'h0602_0000_0000_0000, 2, 64'h1006_1007_1000_0000, 6,
                    21'd0, 21'd0, 0, 0};
        n_vec = 9;
`endif

        // Reset with a byte waiting: nothing may be popped or driven.
        force_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        force_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_busy", 64'(o_busy), 64'd0);

        for (int i = 0; i < n_vec; i++) run_vec(i, vecs[i]);

        // TX back-pressure during a read: no pushes, no timeout, order kept.
        tx0 = tx_n;
        t0  = tmo_n;
        pc_rdy = 1'b0;
        push(8'h27);
        push(8'h01);
        repeat (20) @(negedge clk);
        check("stall_ntx", 64'(tx_n - tx0), 64'd0);
        check("stall_busy", 64'(o_busy), 64'd1);
        check("stall_ntmo", 64'(tmo_n - t0), 64'd0);
        pc_rdy = 1'b1;
        wait_done("stall");
        check("stall_ntx_after", 64'(tx_n - tx0), 64'(4 + RdExtra));
        check("stall_b0", 64'(tx_buf[tx0]),   64'hBE);
        check("stall_b1", 64'(tx_buf[tx0+1]), 64'hEF);
        check("stall_b2", 64'(tx_buf[tx0+2]), 64'h00);
        check("stall_b3", 64'(tx_buf[tx0+3]), 64'h42);
        check("stall_ntmo_after", 64'(tmo_n - t0), 64'd0);

        // Reset mid-write-frame: frame abandoned, outputs quiet.
        tx0 = tx_n;
        wr0 = wr_n;
        push(8'h82);
        push(8'h01);
        push(8'h12);
        repeat (3) @(negedge clk);
        check("mid_busy", 64'(o_busy), 64'd1);
        rst_n = 1'b0;
        force_valid = 1'b1;
        repeat (2) @(negedge clk);
        check_quiet("mid_reset");
        rst_n = 1'b1;
        force_valid = 1'b0;
        repeat (25) @(negedge clk);
        check("mid_after_busy", 64'(o_busy), 64'd0);
        check("mid_after_nwr", 64'(wr_n - wr0), 64'd0);
        check("mid_after_ntx", 64'(tx_n - tx0), 64'd0);

        // Recovery: a plain read of bank0 addr1.
        tx0 = tx_n;
        push(8'h01);
        push(8'h00);
        wait_done("recover");
        check("recover_ntx", 64'(tx_n - tx0), 64'(2 + RdExtra));
        check("recover_b0", 64'(tx_buf[tx0]),   64'h10);
        check("recover_b1", 64'(tx_buf[tx0+1]), 64'h01);

        check("handshake_violations", 64'(proto_bad), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
